// File: rtl/mem_bus_pkg.sv
// Shared defaults and types for the unified memory-port arbiter.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // One memory transaction at the default widths.
  typedef struct packed {
    logic                    we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wd;
    logic [DATA_W_DEF/8-1:0] mask;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant picker: first requester at or after the pointer. The pointer moves
// past the last completed port in round-robin mode and stays at 0 in fixed-priority mode.
module rr_arbiter #(
  parameter int N       = 2,
  parameter bit RR_MODE = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] req_i,
  input  logic         upd_i,
  input  logic [N-1:0] upd_gnt_i,
  output logic [N-1:0] gnt_o
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Scan N positions starting at the pointer; the first asserted request wins.
  always_comb begin
    logic found;
    logic hit;
    gnt_o = '0;
    found = 1'b0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        hit      = !found && req_i[j] && (j == ((int'(ptr_q) + k) % N));
        gnt_o[j] = gnt_o[j] | hit;
        found    = found | hit;
      end
    end
  end

  // Pointer update on completion.
  always_comb begin
    ptr_d = ptr_q;
    if (RR_MODE && upd_i) begin
      for (int j = 0; j < N; j++) begin
        ptr_d = upd_gnt_i[j] ? PTR_W'((j + 1) % N) : ptr_d;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between NUM_PORTS req/wait requesters. One transaction is in
// flight at a time (IDLE -> BUSY -> DONE); the winner comes from rr_arbiter.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit RR_MODE   = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_PORTS-1:0]          p_req_i,
  input  logic [NUM_PORTS-1:0]          p_we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   p_wd_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0] p_mask_i,
  output logic [DATA_W-1:0]             p_rd_o,
  output logic [NUM_PORTS-1:0]          p_wait_o,
  output logic [NUM_PORTS-1:0]          p_done_o,
  output logic                          m_req_o,
  output logic                          m_we_o,
  output logic [ADDR_W-1:0]             m_addr_o,
  output logic [DATA_W-1:0]             m_wd_o,
  output logic [DATA_W/8-1:0]           m_mask_o,
  input  logic [DATA_W-1:0]             m_rd_i,
  input  logic                          m_ack_i
);
  localparam int MASK_W = DATA_W / 8;

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_s, gnt_q, gnt_d;
  logic [NUM_PORTS-1:0] p_done_q, p_done_d;
  logic [DATA_W-1:0]    p_rd_q, p_rd_d;
  logic                 m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0]    m_addr_q, m_addr_d;
  logic [DATA_W-1:0]    m_wd_q, m_wd_d;
  logic [MASK_W-1:0]    m_mask_q, m_mask_d;
  logic                 sel_we_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_wd_s;
  logic [MASK_W-1:0]    sel_mask_s;
  logic                 upd_s;

  rr_arbiter #(.N(NUM_PORTS), .RR_MODE(RR_MODE)) u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (p_req_i),
    .upd_i     (upd_s),
    .upd_gnt_i (gnt_q),
    .gnt_o     (gnt_s)
  );

  // AND-OR mux of the winning port's fields out of the packed buses.
  always_comb begin
    sel_we_s   = 1'b0;
    sel_addr_s = '0;
    sel_wd_s   = '0;
    sel_mask_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_we_s   = sel_we_s   | (gnt_s[i] & p_we_i[i]);
      sel_addr_s = sel_addr_s | ({ADDR_W{gnt_s[i]}} & p_addr_i[i*ADDR_W +: ADDR_W]);
      sel_wd_s   = sel_wd_s   | ({DATA_W{gnt_s[i]}} & p_wd_i[i*DATA_W +: DATA_W]);
      sel_mask_s = sel_mask_s | ({MASK_W{gnt_s[i]}} & p_mask_i[i*MASK_W +: MASK_W]);
    end
  end

  // Next-state logic; m_* stay frozen from grant through completion.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    m_req_d  = m_req_q;
    m_we_d   = m_we_q;
    m_addr_d = m_addr_q;
    m_wd_d   = m_wd_q;
    m_mask_d = m_mask_q;
    p_rd_d   = p_rd_q;
    p_done_d = '0;
    upd_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|p_req_i) begin
          state_d  = BUSY;
          gnt_d    = gnt_s;
          m_req_d  = 1'b1;
          m_we_d   = sel_we_s;
          m_addr_d = sel_addr_s;
          m_wd_d   = sel_wd_s;
          m_mask_d = sel_we_s ? sel_mask_s : '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (m_ack_i) begin
          state_d  = DONE;
          m_req_d  = 1'b0;
          p_rd_d   = m_we_q ? p_rd_q : m_rd_i;
          p_done_d = gnt_q;
          upd_s    = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      m_req_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_addr_q <= '0;
      m_wd_q   <= '0;
      m_mask_q <= '0;
      p_rd_q   <= '0;
      p_done_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      m_req_q  <= m_req_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
      m_wd_q   <= m_wd_d;
      m_mask_q <= m_mask_d;
      p_rd_q   <= p_rd_d;
      p_done_q <= p_done_d;
    end
  end

  assign p_wait_o = p_req_i & ~p_done_q;
  assign p_done_o = p_done_q;
  assign p_rd_o   = p_rd_q;
  assign m_req_o  = m_req_q;
  assign m_we_o   = m_we_q;
  assign m_addr_o = m_addr_q;
  assign m_wd_o   = m_wd_q;
  assign m_mask_o = m_mask_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance (0) and a fixed-priority instance (1)
// run side by side against a transaction-level model, with directed and random traffic.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MW   = 4;
  localparam int NI   = 2;
  localparam int MEMW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]    p_req [NI];
  logic [N-1:0]    p_we  [NI];
  logic [N*AW-1:0] p_addr[NI];
  logic [N*DW-1:0] p_wd  [NI];
  logic [N*MW-1:0] p_mask[NI];
  logic [DW-1:0]   p_rd  [NI];
  logic [N-1:0]    p_wait[NI];
  logic [N-1:0]    p_done[NI];
  logic            m_req [NI];
  logic            m_we  [NI];
  logic [AW-1:0]   m_addr[NI];
  logic [DW-1:0]   m_wd  [NI];
  logic [MW-1:0]   m_mask[NI];
  logic [DW-1:0]   m_rd  [NI];
  logic            m_ack [NI];

  mem_bus_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1)) dut_rr (
    .clk_i(clk), .reset_i(reset), .p_req_i(p_req[0]), .p_we_i(p_we[0]), .p_addr_i(p_addr[0]),
    .p_wd_i(p_wd[0]), .p_mask_i(p_mask[0]), .p_rd_o(p_rd[0]), .p_wait_o(p_wait[0]),
    .p_done_o(p_done[0]), .m_req_o(m_req[0]), .m_we_o(m_we[0]), .m_addr_o(m_addr[0]),
    .m_wd_o(m_wd[0]), .m_mask_o(m_mask[0]), .m_rd_i(m_rd[0]), .m_ack_i(m_ack[0]));

  mem_bus_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0)) dut_fp (
    .clk_i(clk), .reset_i(reset), .p_req_i(p_req[1]), .p_we_i(p_we[1]), .p_addr_i(p_addr[1]),
    .p_wd_i(p_wd[1]), .p_mask_i(p_mask[1]), .p_rd_o(p_rd[1]), .p_wait_o(p_wait[1]),
    .p_done_o(p_done[1]), .m_req_o(m_req[1]), .m_we_o(m_we[1]), .m_addr_o(m_addr[1]),
    .m_wd_o(m_wd[1]), .m_mask_o(m_mask[1]), .m_rd_i(m_rd[1]), .m_ack_i(m_ack[1]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // requesters: mode 0 = directed one-shot, 1 = continuous reads, 2 = random
  mem_req_t rq     [NI][N];
  bit       rq_act [NI][N];
  int       rq_mode[NI][N];

  // reference model: a transaction is either absent, in flight, or just completed
  bit            rr_of  [NI];
  int            phase  [NI];
  int            owner  [NI];
  int            ptr    [NI];
  mem_req_t      cur    [NI];
  bit            e_mreq [NI];
  logic [DW-1:0] e_rd   [NI];
  logic [N-1:0]  e_done [NI];
  int            glog   [NI][$];

  // memory
  logic [DW-1:0] mem [NI][MEMW];
  int            ack_dly[NI];
  int            ack_cnt[NI];
  bit            rand_dly;
  bit            stray;

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic update_requesters(input int k);
    for (int p = 0; p < N; p++) begin
      if (e_done[k][p]) rq_act[k][p] = 1'b0;
      if (rq_mode[k][p] == 1 && !rq_act[k][p]) begin
        rq[k][p].we   = 1'b0;
        rq[k][p].addr = 32'h100 + 32'(4 * p);
        rq[k][p].wd   = $urandom;
        rq[k][p].mask = 4'($urandom_range(0, 15));
        rq_act[k][p]  = 1'b1;
      end else if (rq_mode[k][p] == 2) begin
        if (!rq_act[k][p]) begin
          if ($urandom_range(0, 1) == 1) begin
            rq[k][p].we   = 1'($urandom_range(0, 1));
            rq[k][p].addr = 32'($urandom_range(0, MEMW - 1)) << 2;
            rq[k][p].wd   = $urandom;
            rq[k][p].mask = 4'($urandom_range(0, 15));
            rq_act[k][p]  = 1'b1;
          end
        end else if (!(phase[k] != 0 && owner[k] == p) && $urandom_range(0, 7) == 0) begin
          rq_act[k][p] = 1'b0;
        end
      end
      p_req[k][p]            = rq_act[k][p];
      p_we[k][p]             = rq[k][p].we;
      p_addr[k][p*AW +: AW]  = rq[k][p].addr;
      p_wd[k][p*DW +: DW]    = rq[k][p].wd;
      p_mask[k][p*MW +: MW]  = rq[k][p].mask;
    end
  endtask

  task automatic mem_drive(input int k);
    int idx;
    m_ack[k] = 1'b0;
    m_rd[k]  = $urandom;
    if (e_mreq[k]) begin
      if (ack_cnt[k] >= ack_dly[k]) begin
        m_ack[k] = 1'b1;
        idx = int'(cur[k].addr[7:2]);
        if (cur[k].we) begin
          for (int b = 0; b < MW; b++)
            if (cur[k].mask[b]) mem[k][idx][b*8 +: 8] = cur[k].wd[b*8 +: 8];
        end else begin
          m_rd[k] = mem[k][idx];
        end
        ack_cnt[k] = 0;
        if (rand_dly) ack_dly[k] = $urandom_range(0, 3);
      end else begin
        ack_cnt[k]++;
      end
    end else begin
      ack_cnt[k] = 0;
      if (stray && $urandom_range(0, 7) == 0) m_ack[k] = 1'b1;
    end
  endtask

  task automatic model_step(input int k);
    int g;
    g = -1;
    e_done[k] = '0;
    if (reset) begin
      phase[k] = 0; ptr[k] = 0; cur[k] = '0; e_mreq[k] = 1'b0; e_rd[k] = '0;
    end else if (phase[k] == 1) begin
      if (m_ack[k]) begin
        e_mreq[k] = 1'b0;
        if (!cur[k].we) e_rd[k] = m_rd[k];
        e_done[k][owner[k]] = 1'b1;
        if (rr_of[k]) ptr[k] = (owner[k] + 1) % N;
        phase[k] = 2;
      end
    end else if (phase[k] == 2) begin
      phase[k] = 0;
    end else if (p_req[k] != '0) begin
      for (int s = 0; s < N; s++) begin
        int c;
        c = rr_of[k] ? (ptr[k] + s) % N : s;
        if (g < 0 && p_req[k][c]) g = c;
      end
      owner[k] = g;
      glog[k].push_back(g);
      cur[k].we   = p_we[k][g];
      cur[k].addr = p_addr[k][g*AW +: AW];
      cur[k].wd   = p_wd[k][g*DW +: DW];
      cur[k].mask = p_we[k][g] ? p_mask[k][g*MW +: MW] : 4'b0000;
      e_mreq[k]   = 1'b1;
      phase[k]    = 1;
    end
  endtask

  task automatic compare(input int k);
    chk("m_req",  k, 32'(m_req[k]),  32'(e_mreq[k]));
    chk("m_we",   k, 32'(m_we[k]),   32'(cur[k].we));
    chk("m_addr", k, m_addr[k],      cur[k].addr);
    chk("m_wd",   k, m_wd[k],        cur[k].wd);
    chk("m_mask", k, 32'(m_mask[k]), 32'(cur[k].mask));
    chk("p_done", k, 32'(p_done[k]), 32'(e_done[k]));
    chk("p_wait", k, 32'(p_wait[k]), 32'(p_req[k] & ~e_done[k]));
    chk("p_rd",   k, p_rd[k],        e_rd[k]);
  endtask

  task automatic step();
    for (int k = 0; k < NI; k++) begin
      update_requesters(k);
      mem_drive(k);
    end
    for (int k = 0; k < NI; k++) model_step(k);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NI; k++) compare(k);
  endtask

  task automatic wait_done(input int k, input int p, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      seen = e_done[k][p];
    end
    chk("done_within_bound", k, 32'(seen), 32'd1);
  endtask

  task automatic set_txn(input int k, input int p, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] mask);
    rq[k][p].we = we; rq[k][p].addr = addr; rq[k][p].wd = wd; rq[k][p].mask = mask;
    rq_mode[k][p] = 0;
    rq_act[k][p]  = 1'b1;
  endtask

  initial begin
    int n1;
    reset = 1'b1;
    rand_dly = 1'b0;
    stray = 1'b0;
    rr_of[0] = 1'b1;
    rr_of[1] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      phase[k] = 0; owner[k] = 0; ptr[k] = 0; cur[k] = '0;
      e_mreq[k] = 1'b0; e_rd[k] = '0; e_done[k] = '0;
      ack_dly[k] = 0; ack_cnt[k] = 0;
      for (int a = 0; a < MEMW; a++) mem[k][a] = '0;
      mem[k][16] = 32'hDEAD_BEEF;
      for (int p = 0; p < N; p++) begin
        rq[k][p] = '0; rq_act[k][p] = 1'b0; rq_mode[k][p] = 0;
      end
    end

    // reset with both ports requesting, then zero-wait reads from port 0 and port 1
    for (int k = 0; k < NI; k++) begin
      set_txn(k, 0, 1'b0, 32'h10, 32'h0, 4'hF);
      set_txn(k, 1, 1'b0, 32'h40, 32'h0, 4'hF);
    end
    step(); step();
    for (int k = 0; k < NI; k++) begin
      chk("reset_p_wait", k, 32'(p_wait[k]), 32'h3);
      chk("reset_m_req",  k, 32'(m_req[k]),  32'h0);
    end
    reset = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      chk("first_m_req",  k, 32'(m_req[k]), 32'h1);
      chk("first_m_addr", k, m_addr[k],     32'h10);
    end
    step();
    for (int k = 0; k < NI; k++) chk("first_done", k, 32'(p_done[k]), 32'h1);
    step(); step();
    for (int k = 0; k < NI; k++) begin
      chk("p1_m_addr", k, m_addr[k],      32'h40);
      chk("p1_wait",   k, 32'(p_wait[k]), 32'h2);
    end
    step();
    for (int k = 0; k < NI; k++) begin
      chk("p1_done", k, 32'(p_done[k]), 32'h2);
      chk("p1_rd",   k, p_rd[k],        32'hDEAD_BEEF);
      chk("p1_wait_released", k, 32'(p_wait[k]), 32'h0);
    end
    step();

    // both ports continuously requesting, ack delay 3
    for (int k = 0; k < NI; k++) begin
      glog[k].delete();
      ack_dly[k] = 3;
      rq_mode[k][0] = 1;
      rq_mode[k][1] = 1;
    end
    for (int i = 0; i < 26; i++) step();
    chk("rr_grant_count", 0, 32'(glog[0].size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < glog[0].size(); i++)
      chk("rr_grant_seq", 0, 32'(glog[0][i]), 32'(i % 2));
    n1 = 0;
    foreach (glog[1][i]) if (glog[1][i] == 1) n1++;
    chk("fp_grant_count",   1, 32'(glog[1].size() >= 4), 32'h1);
    chk("fp_port1_starved", 1, 32'(n1), 32'h0);
    rq_mode[1][0] = 0;
    wait_done(1, 1, 30);
    for (int k = 0; k < NI; k++) begin
      rq_mode[k][0] = 0;
      rq_mode[k][1] = 0;
    end
    for (int i = 0; i < 24; i++) step();

    // masked write, then read-back through the other port
    for (int k = 0; k < NI; k++) set_txn(k, 0, 1'b1, 32'h80, 32'h1234_5678, 4'b0011);
    step();
    for (int k = 0; k < NI; k++) begin
      chk("wr_m_we",   k, 32'(m_we[k]),   32'h1);
      chk("wr_m_mask", k, 32'(m_mask[k]), 32'h3);
      chk("wr_m_wd",   k, m_wd[k],        32'h1234_5678);
    end
    wait_done(0, 0, 20);
    for (int k = 0; k < NI; k++) set_txn(k, 1, 1'b0, 32'h80, 32'hFFFF_FFFF, 4'hF);
    wait_done(0, 1, 20);
    for (int k = 0; k < NI; k++) chk("readback", k, p_rd[k], 32'h0000_5678);
    step();

    // reset while busy aborts, then the still-requesting port completes
    for (int k = 0; k < NI; k++) begin
      mem[k][4]  = 32'hCAFE_0010;
      ack_dly[k] = 10;
      set_txn(k, 0, 1'b0, 32'h10, 32'h0, 4'hF);
    end
    step(); step();
    reset = 1'b1;
    step();
    for (int k = 0; k < NI; k++) begin
      chk("abort_m_req",  k, 32'(m_req[k]),  32'h0);
      chk("abort_p_done", k, 32'(p_done[k]), 32'h0);
    end
    reset = 1'b0;
    for (int k = 0; k < NI; k++) ack_dly[k] = 1;
    wait_done(0, 0, 20);
    for (int k = 0; k < NI; k++) chk("retry_rd", k, p_rd[k], 32'hCAFE_0010);
    step();

    // random traffic with random ack delays, withdrawals and stray acks
    rand_dly = 1'b1;
    stray = 1'b1;
    for (int k = 0; k < NI; k++)
      for (int p = 0; p < N; p++) rq_mode[k][p] = 2;
    for (int i = 0; i < 3000; i++) step();
    for (int k = 0; k < NI; k++)
      for (int p = 0; p < N; p++) rq_mode[k][p] = 0;
    stray = 1'b0;
    for (int i = 0; i < 30; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
